// File: rtl/bank_sched_if.sv
// Bank scheduler request/grant bundle.
// master drives requests and occupancy; slave returns grants and mode.
interface bank_sched_if #(
  parameter int NUM_BANKS = 16,
  parameter int BANK_LOG  = 4,
  parameter int WR_CNT_W  = 7
);
  logic [NUM_BANKS-1:0] bank_req_valid;
  logic [NUM_BANKS-1:0] bank_req_type;
  logic [WR_CNT_W-1:0]  wr_pending_cnt;
  logic                 cmd_ready;
  logic [NUM_BANKS-1:0] grant_o;
  logic                 grant_valid_o;
  logic [BANK_LOG-1:0]  grant_bank_o;
  logic                 grant_type_o;
  logic                 mode_o;
  logic                 turnaround_o;

  modport master (
    output bank_req_valid, bank_req_type,
    output wr_pending_cnt, cmd_ready,
    input  grant_o, grant_valid_o, grant_bank_o,
    input  grant_type_o, mode_o, turnaround_o
  );

  modport slave (
    input  bank_req_valid, bank_req_type,
    input  wr_pending_cnt, cmd_ready,
    output grant_o, grant_valid_o, grant_bank_o,
    output grant_type_o, mode_o, turnaround_o
  );
endinterface

// File: rtl/bank_scheduler.sv
// Round-robin bank grant with watermark-batched read/write turnaround.
// Optional BANK_SCHED_STARVE_GUARD_EN bounds read starvation in write mode.
module bank_scheduler #(
  parameter int NUM_BANKS    = 16,
  parameter int BANK_LOG     = 4,
  parameter int WR_CNT_W     = 7,
  parameter int WR_HIGH      = 48,
  parameter int WR_LOW       = 16,
  parameter int TURN_CYC     = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  bank_sched_if.slave bus
);

  localparam logic [1:0] RD_MODE  = 2'd0;
  localparam logic [1:0] WR_MODE  = 2'd1;
  localparam logic [1:0] TURN_R2W = 2'd2;
  localparam logic [1:0] TURN_W2R = 2'd3;

  localparam logic [WR_CNT_W-1:0] L_WR_HIGH = WR_CNT_W'(WR_HIGH);
  localparam logic [WR_CNT_W-1:0] L_WR_LOW  = WR_CNT_W'(WR_LOW);
  localparam logic [3:0]          L_TURN_LD = 4'(TURN_CYC - 1);

  generate
    if (WR_LOW >= WR_HIGH) begin : g_bad_wm
      $error("bank_scheduler: WR_LOW must be below WR_HIGH");
    end
    if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn
      $error("bank_scheduler: TURN_CYC out of range 1..15");
    end
    if ((1 << BANK_LOG) != NUM_BANKS) begin : g_bad_banks
      $error("bank_scheduler: NUM_BANKS must equal 2**BANK_LOG");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("bank_scheduler: STARVE_LIMIT must be positive");
    end
  endgenerate

  logic [1:0]           r_state;
  logic [3:0]           r_turn_cnt;
  logic [BANK_LOG-1:0]  r_ptr;
  logic [NUM_BANKS-1:0] r_grant;
  logic                 r_grant_valid;
  logic [BANK_LOG-1:0]  r_grant_bank;
  logic                 r_grant_type;

  logic [NUM_BANKS-1:0] w_rd_vld;
  logic [NUM_BANKS-1:0] w_wr_vld;
  logic [NUM_BANKS-1:0] w_elig;
  logic                 w_any_rd;
  logic                 w_any_wr;
  logic                 w_mode;
  logic                 w_in_mode;
  logic                 w_starve;
  logic                 w_sw;
  logic [1:0]           w_next;
  logic [3:0]           w_cnt_nxt;
  logic                 w_pick_ok;
  logic [BANK_LOG-1:0]  w_pick;
  logic                 w_do_grant;

  assign w_rd_vld  = bus.bank_req_valid & ~bus.bank_req_type;
  assign w_wr_vld  = bus.bank_req_valid &  bus.bank_req_type;
  assign w_any_rd  = |w_rd_vld;
  assign w_any_wr  = |w_wr_vld;
  assign w_mode    = (r_state == WR_MODE);
  assign w_in_mode = (r_state == RD_MODE) | (r_state == WR_MODE);

  // r_grant doubles as the mask: the bank granted last cycle
  // has not yet dropped its valid.
  assign w_elig = (w_mode ? w_wr_vld : w_rd_vld) & ~r_grant;

`ifdef BANK_SCHED_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] L_STARVE = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] r_starve;

  assign w_starve = (r_starve == L_STARVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_next != WR_MODE) begin
      r_starve <= '0;
    end else if (w_mode && w_any_rd && !w_starve) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_starve = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_turn_cnt;
    w_sw      = 1'b0;
    unique case (1'b1)
      r_state == RD_MODE: begin
        w_sw = (bus.wr_pending_cnt >= L_WR_HIGH)
             | (!w_any_rd && w_any_wr);
        if (w_sw) begin
          w_next    = TURN_R2W;
          w_cnt_nxt = L_TURN_LD;
        end
      end
      r_state == WR_MODE: begin
        w_sw = ((bus.wr_pending_cnt <= L_WR_LOW) && w_any_rd)
             | (!w_any_wr && w_any_rd)
             | w_starve;
        if (w_sw) begin
          w_next    = TURN_W2R;
          w_cnt_nxt = L_TURN_LD;
        end
      end
      r_state == TURN_R2W: begin
        if (r_turn_cnt == 4'd0) w_next = WR_MODE;
        else w_cnt_nxt = r_turn_cnt - 4'd1;
      end
      r_state == TURN_W2R: begin
        if (r_turn_cnt == 4'd0) w_next = RD_MODE;
        else w_cnt_nxt = r_turn_cnt - 4'd1;
      end
      default: begin
        w_next = RD_MODE;
      end
    endcase
  end

  // Search upward from ptr+1; the last step wraps back onto ptr itself.
  always_comb begin
    logic [BANK_LOG-1:0] idx;
    idx       = '0;
    w_pick_ok = 1'b0;
    w_pick    = '0;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      idx = r_ptr + BANK_LOG'(i);
      if (!w_pick_ok && w_elig[idx]) begin
        w_pick_ok = 1'b1;
        w_pick    = idx;
      end
    end
  end

  assign w_do_grant = w_in_mode & ~w_sw
                    & bus.cmd_ready & w_pick_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RD_MODE;
      r_turn_cnt    <= '0;
      r_ptr         <= '1;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_bank  <= '0;
      r_grant_type  <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_turn_cnt    <= w_cnt_nxt;
      r_grant_valid <= w_do_grant;
      r_grant_type  <= w_do_grant & w_mode;
      if (w_do_grant) begin
        r_grant      <= NUM_BANKS'(1) << w_pick;
        r_grant_bank <= w_pick;
        r_ptr        <= w_pick;
      end else begin
        r_grant      <= '0;
        r_grant_bank <= '0;
      end
    end
  end

  assign bus.grant_o       = r_grant;
  assign bus.grant_valid_o = r_grant_valid;
  assign bus.grant_bank_o  = r_grant_bank;
  assign bus.grant_type_o  = r_grant_type;
  assign bus.mode_o        = (r_state == WR_MODE)
                           | (r_state == TURN_W2R);
  assign bus.turnaround_o  = (r_state == TURN_R2W)
                           | (r_state == TURN_W2R);

endmodule

// File: doc/bank_scheduler.md
Name: bank_scheduler

Overview:
- Sits between the 16 per-bank request queues (fed by the address mapper) and the DRAM command layer.
- Each cycle it selects at most one bank whose head request matches the current bus direction (read or write) and grants it the command slot.
- Grants rotate round-robin across banks.
- Read/write direction is switched in batches, driven by write-occupancy watermarks, with a fixed bus-turnaround gap.

Parameters:
- NUM_BANKS, 16, number of banks (bank_group x bank); power of two.
- BANK_LOG, 4, log2(NUM_BANKS).
- WR_CNT_W, 7, width of the write-occupancy count.
- WR_HIGH, 48, write count at or above which read mode drains to write mode.
- WR_LOW, 16, write count at or below which write mode returns to read mode.
- TURN_CYC, 4, idle cycles inserted on every direction change; range 1..15.
- STARVE_LIMIT, 64, read-starvation threshold in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- bank_req_valid  in  NUM_BANKS  bank b has a head request pending
- bank_req_type  in  NUM_BANKS  head request type per bank: 0 = read, 1 = write
- wr_pending_cnt  in  WR_CNT_W  number of writes held in the global array
- cmd_ready  in  1  command layer can accept a command this cycle
- grant_o  out  NUM_BANKS  one-hot grant pulse to the banks
- grant_valid_o  out  1  a grant is issued this cycle
- grant_bank_o  out  BANK_LOG  index of the granted bank
- grant_type_o  out  1  type of the granted request
- mode_o  out  1  current direction: 0 = read, 1 = write
- turnaround_o  out  1  high during turnaround cycles

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - All outputs go to 0; state = RD_MODE.
  - RR pointer = NUM_BANKS-1, so bank 0 has first priority.
  - Turnaround counter = 0; masked-bank register cleared.
- Reset asserted mid-turnaround or mid-batch: the next cycle is RD_MODE with no grant.
- States:
  - RD_MODE: grants reads only.
  - WR_MODE: grants writes only.
  - TURN_R2W and TURN_W2R: no grants; counter loads TURN_CYC-1 on entry and decrements each cycle.
- Eligible set, evaluated combinationally on current inputs:
  - elig[b] = bank_req_valid[b] & (bank_req_type[b] == mode) & ~masked[b].
  - masked[b] is the one-hot of the bank granted in the previous cycle. This covers the bank's one-cycle valid update latency, so no bank is ever double-granted.
- Transitions, evaluated every cycle in this priority order:
  - RD_MODE -> TURN_R2W when wr_pending_cnt >= WR_HIGH, or when no valid read exists and at least one valid write exists.
  - WR_MODE -> TURN_W2R when (wr_pending_cnt <= WR_LOW and a valid read exists), or when no valid write exists and at least one valid read exists.
  - TURN_R2W -> WR_MODE, and TURN_W2R -> RD_MODE, in the cycle after the counter reads 0. Total gap is exactly TURN_CYC cycles.
  - No grant is issued in any cycle whose next state is a TURN state.
- Grant (registered; one-cycle latency):
  - In a mode state with cmd_ready = 1 and elig != 0, pick the first set bit of elig searching upward from pointer+1 with wrap-around at NUM_BANKS-1 -> 0.
  - Next cycle outputs: grant_o = onehot(b), grant_valid_o = 1, grant_bank_o = b, grant_type_o = mode.
  - Pointer updates to b.
  - With cmd_ready = 0 or elig = 0: all grant outputs are 0 next cycle and the pointer holds.
- grant_o is a single-cycle pulse. A bank must hold its request until it sees its grant bit, then advance its head.
- mode_o and turnaround_o are registered copies of the state: mode_o holds the old direction during a TURN state; turnaround_o = 1 only in TURN states.
- Simultaneous conditions:
  - Watermark switch and an eligible request in the same cycle: the switch wins and no grant is issued.
  - wr_pending_cnt is compared unsigned. WR_LOW >= WR_HIGH is illegal; flag it with an elaboration-time assertion.

Optional Feature:
- Macro: BANK_SCHED_STARVE_GUARD_EN.
- Defined:
  - A starvation counter (width sized to hold STARVE_LIMIT) increments each cycle in WR_MODE while any valid read exists. It clears on leaving WR_MODE and on reset.
  - When the counter reaches STARVE_LIMIT, WR_MODE -> TURN_W2R is forced regardless of wr_pending_cnt.
  - The counter saturates and does not wrap.
- Undefined: no counter exists; write batches end only on the watermark and empty conditions above.

Test Plan:
- Reset, then read requests valid on banks 0, 3 and 15 with cmd_ready = 1 and wr_pending_cnt = 0 -> grants to banks 0, 3, 15, 0… on consecutive cycles; grant_valid_o first high 1 cycle after the inputs are applied.
- Read mode with wr_pending_cnt driven 47 -> 48 -> grants stop; turnaround_o high for exactly 4 cycles; then mode_o = 1 and write grants resume.
- Write mode with wr_pending_cnt = 16, a read pending on bank 5, and writes still pending -> TURN_W2R for 4 cycles; then bank 5 is granted a read.
- cmd_ready held 0 for 10 cycles with 4 eligible banks -> no grants and the pointer is unchanged; the first grant after release goes to the bank following the last-granted bank.
- A single bank 7 holds a read valid continuously -> grants on alternate cycles only (the mask prevents back-to-back grants to bank 7).
- With BANK_SCHED_STARVE_GUARD_EN defined, write mode, wr_pending_cnt = 30, and a read on bank 2 for 64 cycles -> forced turnaround, then bank 2 granted. Without the macro -> write mode persists.
